// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: registered RV32 memory stage with word RAM, byte-lane stores and sign/zero-extended loads.
// Optional MEM_STAGE_PERF_EN adds stall_cnt and fault_cnt counters.
module mem_stage_pipe #(
    parameter int XLEN = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [4:0]      rd_in,
    input  logic            reg_write_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_fault
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [15:0]     fault_cnt
`endif
);
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic            accept, is_mem, bad_f3, misaligned, fault, do_store;
    logic [IDX_W-1:0] idx;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [31:0]     wword, rword, shifted, ld_data, nxt_data;
    logic            unused;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign idx        = alu_result[IDX_W+1:2];
    assign lane       = alu_result[1:0];
    assign is_mem     = mem_read || mem_write;
    assign bad_f3     = funct3[1:0] == 2'b11 || funct3 == 3'b110;
    assign misaligned = (funct3[1:0] == 2'b01 && lane[0]) || (funct3[1:0] == 2'b10 && lane != 2'b00);
    assign fault      = is_mem && (bad_f3 || misaligned);
    assign do_store   = accept && mem_write && !fault;
    assign unused     = ^{alu_result[XLEN-1:IDX_W+2], shifted[31:16]};

    always_comb begin
        be = funct3[1:0] == 2'b00 ? 4'b0001 << lane :
             funct3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wword = funct3[1:0] == 2'b00 ? {4{mem_wdata[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{mem_wdata[15:0]}} : mem_wdata;
        rword = mem[idx];
        shifted = rword >> {lane, 3'b000};
        ld_data = funct3 == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                  funct3 == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                  funct3 == 3'b100 ? {24'd0, shifted[7:0]} :
                  funct3 == 3'b101 ? {16'd0, shifted[15:0]} : rword;
        // both flags set behaves as a store, so only a pure load returns RAM data
        nxt_data = fault ? '0 : (mem_read && !mem_write) ? ld_data : alu_result;
    end

    always_ff @(posedge clk) begin
        if (do_store)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_fault     <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_data      <= nxt_data;
            out_rd        <= rd_in;
            out_reg_write <= reg_write_in && !fault;
            out_fault     <= fault;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fault_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (accept && fault && fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
        end
    end
`endif
endmodule
